// File: rtl/lm_sm_sequencer_pkg.sv
// Shared pipeline definitions for the LM/SM micro-sequencer: opcodes,
// instruction field positions and the sequencer state encoding.
package lm_sm_sequencer_pkg;

    localparam logic [3:0]  DEF_LM_OPCODE = 4'b0110;
    localparam logic [3:0]  DEF_SM_OPCODE = 4'b0111;
    localparam logic [15:0] DEF_ADDR_STEP = 16'd2;

    localparam int IR_OPC_HI  = 15;
    localparam int IR_OPC_LO  = 12;
    localparam int IR_RA_HI   = 11;
    localparam int IR_RA_LO   = 9;
    localparam int IR_LIST_HI = 7;
    localparam int IR_LIST_LO = 0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    function automatic logic [3:0] ir_opcode(input logic [15:0] ir);
        return ir[IR_OPC_HI:IR_OPC_LO];
    endfunction

    function automatic logic [2:0] ir_ra(input logic [15:0] ir);
        return ir[IR_RA_HI:IR_RA_LO];
    endfunction

    function automatic logic [7:0] ir_list(input logic [15:0] ir);
        return ir[IR_LIST_HI:IR_LIST_LO];
    endfunction

endpackage

// File: rtl/lm_sm_sequencer_if.sv
// ID-stage bundle between the pipeline and the LM/SM sequencer.
// Handshake: a micro-op is consumed on a rising edge where UOP_VALID=1 and
// STALL_IN=0; while STALL_IN=1 every output holds and nothing is consumed.
interface lm_sm_sequencer_if;
    import lm_sm_sequencer_pkg::*;

    logic [15:0] ID_IR;
    logic        ID_VALID;
    logic        STALL_IN;
    logic        FLUSH;
    logic        SEQ_CLAIM;
    logic        IF_ID_HOLD;
    logic        UOP_VALID;
    logic        UOP_IS_LOAD;
    logic [2:0]  UOP_BASE;
    logic [2:0]  UOP_REG;
    logic [15:0] UOP_OFFSET;
    logic        UOP_FIRST;
    logic        UOP_LAST;
    seq_state_e  DBG_STATE;

    modport master (
        input  ID_IR, ID_VALID, STALL_IN, FLUSH,
        output SEQ_CLAIM, IF_ID_HOLD, UOP_VALID, UOP_IS_LOAD, UOP_BASE,
               UOP_REG, UOP_OFFSET, UOP_FIRST, UOP_LAST, DBG_STATE
    );

    modport slave (
        output ID_IR, ID_VALID, STALL_IN, FLUSH,
        input  SEQ_CLAIM, IF_ID_HOLD, UOP_VALID, UOP_IS_LOAD, UOP_BASE,
               UOP_REG, UOP_OFFSET, UOP_FIRST, UOP_LAST, DBG_STATE
    );

endinterface

// File: rtl/lm_sm_sequencer_reg_list_pick.sv
// Picks the lowest-numbered register in an LM/SM list (bit 7 is R0) and
// reports its clear mask and whether it is the only one left.
module lm_sm_sequencer_reg_list_pick (
    input  logic [7:0] mask_i,
    output logic [2:0] idx_o,
    output logic [7:0] clr_o,
    output logic       single_o
);

    logic found;

    always_comb begin
        idx_o = '0;
        clr_o = '0;
        found = 1'b0;
        for (int r = 0; r < 8; r++) begin
            if (!found && mask_i[7-r]) begin
                idx_o      = 3'(r);
                clr_o[7-r] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign single_o = (mask_i != 8'd0) && ((mask_i & (mask_i - 8'd1)) == 8'd0);

endmodule

// File: rtl/lm_sm_sequencer.sv
// ID-stage micro-sequencer: expands LM/SM into one memory micro-op per set
// register-list bit, holding IF/ID until the final micro-op issues.
module lm_sm_sequencer
    import lm_sm_sequencer_pkg::*;
#(
    parameter logic [3:0]  LM_OPCODE = DEF_LM_OPCODE,
    parameter logic [3:0]  SM_OPCODE = DEF_SM_OPCODE,
    parameter logic [15:0] ADDR_STEP = DEF_ADDR_STEP
) (
    input  logic               CLK,
    input  logic               RST,
    lm_sm_sequencer_if.master  bus
);

    seq_state_e  state_q, state_d;
    logic [7:0]  mask_q, mask_d;
    logic [15:0] offset_q, offset_d;
    logic [2:0]  base_q, base_d;
    logic        is_load_q, is_load_d;
    logic        first_q, first_d;

    logic [3:0]  opcode;
    logic [7:0]  list;
    logic        is_lmsm;
    logic        accept;
    logic        running;
    logic        uop_valid;
    logic [2:0]  pick_idx;
    logic [7:0]  pick_clr;
    logic        pick_single;

    lm_sm_sequencer_reg_list_pick u_pick (
        .mask_i   (mask_q),
        .idx_o    (pick_idx),
        .clr_o    (pick_clr),
        .single_o (pick_single)
    );

    assign opcode    = ir_opcode(bus.ID_IR);
    assign list      = ir_list(bus.ID_IR);
    assign is_lmsm   = (opcode == LM_OPCODE) || (opcode == SM_OPCODE);
    assign running   = (state_q == RUN);
    assign accept    = !running && bus.ID_VALID && is_lmsm && !bus.STALL_IN && !bus.FLUSH;
    // A flush kills the in-flight micro-op in the same cycle it arrives.
    assign uop_valid = running && !bus.FLUSH;

    assign bus.SEQ_CLAIM   = accept || running;
    assign bus.IF_ID_HOLD  = (accept && (list != 8'd0)) || (uop_valid && !pick_single);
    assign bus.UOP_VALID   = uop_valid;
    assign bus.UOP_IS_LOAD = uop_valid && is_load_q;
    assign bus.UOP_BASE    = uop_valid ? base_q : 3'd0;
    assign bus.UOP_REG     = uop_valid ? pick_idx : 3'd0;
    assign bus.UOP_OFFSET  = uop_valid ? offset_q : 16'd0;
    assign bus.UOP_FIRST   = uop_valid && first_q;
    assign bus.UOP_LAST    = uop_valid && pick_single;
    assign bus.DBG_STATE   = state_q;

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        offset_d  = offset_q;
        base_d    = base_q;
        is_load_d = is_load_q;
        first_d   = first_q;
        if (running) begin
            if (bus.FLUSH) begin
                state_d = IDLE;
                mask_d  = 8'd0;
                first_d = 1'b0;
            end else if (!bus.STALL_IN) begin
                mask_d   = mask_q & ~pick_clr;
                offset_d = offset_q + ADDR_STEP;
                first_d  = 1'b0;
                if (pick_single) begin
                    state_d = IDLE;
                end
            end
        end else if (accept && (list != 8'd0)) begin
            // Zero-list instructions retire as a bubble without entering RUN.
            state_d   = RUN;
            mask_d    = list;
            offset_d  = 16'd0;
            base_d    = ir_ra(bus.ID_IR);
            is_load_d = (opcode == LM_OPCODE);
            first_d   = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            mask_q    <= 8'd0;
            offset_q  <= 16'd0;
            base_q    <= 3'd0;
            is_load_q <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            offset_q  <= offset_d;
            base_q    <= base_d;
            is_load_q <= is_load_d;
            first_q   <= first_d;
        end
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer: per-scenario tasks with inline
// checks, plus a micro-op scoreboard fed from the stimulus side.
module tb_lm_sm_sequencer;
    import lm_sm_sequencer_pkg::*;

    localparam int UW = 25;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lm_sm_sequencer_if bus ();

    lm_sm_sequencer dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [UW-1:0] exp_q[$];
    logic [UW-1:0] mon_got;
    logic [UW-1:0] mon_exp;

    function automatic logic [UW-1:0] pack_uop(input logic ld, input logic [2:0] base,
                                               input logic [2:0] r, input logic [15:0] off,
                                               input logic first, input logic last);
        return {ld, base, r, off, first, last};
    endfunction

    function automatic logic [2:0] ctl();
        return {bus.SEQ_CLAIM, bus.IF_ID_HOLD, bus.UOP_VALID};
    endfunction

    function automatic logic [27:0] all_out();
        return {bus.SEQ_CLAIM, bus.IF_ID_HOLD, bus.UOP_VALID, bus.UOP_IS_LOAD, bus.UOP_BASE,
                bus.UOP_REG, bus.UOP_OFFSET, bus.UOP_FIRST, bus.UOP_LAST};
    endfunction

    // Consumed micro-ops are compared in order against the expected queue.
    always @(negedge clk) begin
        if (bus.UOP_VALID === 1'b1 && bus.STALL_IN === 1'b0) begin
            mon_got = pack_uop(bus.UOP_IS_LOAD, bus.UOP_BASE, bus.UOP_REG, bus.UOP_OFFSET,
                               bus.UOP_FIRST, bus.UOP_LAST);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL uop_unexpected got=%h required=none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL uop got=%h required=%h (ld,base,reg,off,first,last)",
                             mon_got, mon_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "time limit");
    end

    task automatic set_in(input logic [15:0] ir, input logic v, input logic st, input logic fl);
        bus.ID_IR    = ir;
        bus.ID_VALID = v;
        bus.STALL_IN = st;
        bus.FLUSH    = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] make_ir(input logic ld, input logic [2:0] ra, input logic [7:0] mask);
        logic [3:0] opc;
        logic       b8;
        opc = ld ? 4'b0110 : 4'b0111;
        b8  = 1'($urandom_range(0, 1));
        return {opc, ra, b8, mask};
    endfunction

    function automatic int popcount8(input logic [7:0] m);
        int n = 0;
        for (int i = 0; i < 8; i++) if (m[i]) n++;
        return n;
    endfunction

    task automatic push_expected(input logic ld, input logic [2:0] ra, input logic [7:0] mask);
        int n;
        int k;
        n = popcount8(mask);
        k = 0;
        for (int r = 0; r < 8; r++) begin
            if (mask[7-r]) begin
                exp_q.push_back(pack_uop(ld, ra, 3'(r), 16'(2 * k), k == 0, k == n - 1));
                k++;
            end
        end
    endtask

    // Accept at T, then N micro-op cycles; returns right after cycle T+N is sampled.
    task automatic run_seq(input logic ld, input logic [2:0] ra, input logic [7:0] mask);
        int n;
        logic [15:0] ir;
        n  = popcount8(mask);
        ir = make_ir(ld, ra, mask);
        push_expected(ld, ra, mask);
        next_cycle();
        set_in(ir, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.DBG_STATE !== IDLE) begin
            errors++;
            $display("FAIL accept_state got=%0d required=%0d", bus.DBG_STATE, IDLE);
        end
        checks++;
        if (ctl() !== {1'b1, n != 0, 1'b0}) begin
            errors++;
            $display("FAIL accept_ctl mask=%b got=%b required=%b", mask, ctl(), {1'b1, n != 0, 1'b0});
        end
        for (int k = 1; k <= n; k++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (ctl() !== {1'b1, k < n, 1'b1}) begin
                errors++;
                $display("FAIL run_ctl mask=%b k=%0d got=%b required=%b", mask, k, ctl(), {1'b1, k < n, 1'b1});
            end
        end
    endtask

    task automatic idle_check(input string name);
        next_cycle();
        set_in(16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (ctl() !== 3'b000 || bus.DBG_STATE !== IDLE) begin
            errors++;
            $display("FAIL %s ctl=%b state=%0d required ctl=000 state=0", name, ctl(), bus.DBG_STATE);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(16'h0000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (all_out() !== 28'd0 || bus.DBG_STATE !== IDLE) begin
            errors++;
            $display("FAIL reset_outputs got=%h state=%0d required=0", all_out(), bus.DBG_STATE);
        end
    endtask

    task automatic test_lm_basic();
        run_seq(1'b1, 3'd1, 8'b1010_0001);
        idle_check("lm_basic_after");
    endtask

    task automatic test_sm_full();
        run_seq(1'b0, 3'd3, 8'hFF);
        idle_check("sm_full_after");
    endtask

    task automatic test_zero_mask();
        run_seq(1'b1, 3'd2, 8'h00);
        run_seq(1'b0, 3'd5, 8'b0100_0000);
        idle_check("zero_mask_after");
    endtask

    task automatic test_stall();
        logic [15:0] ir;
        ir = make_ir(1'b1, 3'd6, 8'b1110_0000);
        next_cycle();
        set_in(ir, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (ctl() !== 3'b000) begin
            errors++;
            $display("FAIL stall_idle_no_accept got=%b required=000", ctl());
        end
        push_expected(1'b1, 3'd6, 8'b1110_0000);
        next_cycle();
        bus.STALL_IN = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl() !== 3'b110) begin
            errors++;
            $display("FAIL stall_accept got=%b required=110", ctl());
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({bus.UOP_REG, bus.UOP_OFFSET, bus.UOP_FIRST} !== {3'd0, 16'd0, 1'b1}) begin
            errors++;
            $display("FAIL stall_first reg=%0d off=%0d first=%b required 0,0,1",
                     bus.UOP_REG, bus.UOP_OFFSET, bus.UOP_FIRST);
        end
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            bus.STALL_IN = (c < 3);
            @(negedge clk);
            checks++;
            if ({bus.UOP_REG, bus.UOP_OFFSET, bus.UOP_FIRST, bus.UOP_LAST, bus.UOP_VALID, bus.IF_ID_HOLD}
                !== {3'd1, 16'd2, 1'b0, 1'b0, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL stall_frozen c=%0d reg=%0d off=%0d first=%b last=%b valid=%b hold=%b required 1,2,0,0,1,1",
                         c, bus.UOP_REG, bus.UOP_OFFSET, bus.UOP_FIRST, bus.UOP_LAST, bus.UOP_VALID, bus.IF_ID_HOLD);
            end
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({bus.UOP_REG, bus.UOP_OFFSET, bus.UOP_LAST, bus.IF_ID_HOLD} !== {3'd2, 16'd4, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL stall_last reg=%0d off=%0d last=%b hold=%b required 2,4,1,0",
                     bus.UOP_REG, bus.UOP_OFFSET, bus.UOP_LAST, bus.IF_ID_HOLD);
        end
        idle_check("stall_after");
    endtask

    task automatic test_flush();
        next_cycle();
        set_in(make_ir(1'b1, 3'd0, 8'h81), 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (ctl() !== 3'b000) begin
            errors++;
            $display("FAIL flush_idle_no_accept got=%b required=000", ctl());
        end
        push_expected(1'b0, 3'd2, 8'b0000_1111);
        next_cycle();
        set_in(make_ir(1'b0, 3'd2, 8'b0000_1111), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (ctl() !== 3'b110) begin
            errors++;
            $display("FAIL flush_accept got=%b required=110", ctl());
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (ctl() !== 3'b111) begin
            errors++;
            $display("FAIL flush_first_uop got=%b required=111", ctl());
        end
        next_cycle();
        bus.FLUSH = 1'b1;
        bus.STALL_IN = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.IF_ID_HOLD, bus.UOP_VALID} !== 2'b00) begin
            errors++;
            $display("FAIL flush_same_cycle hold,valid=%b required=00", {bus.IF_ID_HOLD, bus.UOP_VALID});
        end
        checks++;
        if (exp_q.size() != 3) begin
            errors++;
            $display("FAIL flush_pending got=%0d required=3", exp_q.size());
        end
        exp_q.delete();
        bus.STALL_IN = 1'b0;
        run_seq(1'b1, 3'd3, 8'b1001_0000);
        idle_check("flush_after");
    endtask

    task automatic test_reset_mid();
        push_expected(1'b1, 3'd0, 8'b1111_1000);
        next_cycle();
        set_in(make_ir(1'b1, 3'd0, 8'b1111_1000), 1'b1, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.UOP_REG !== 3'd1) begin
            errors++;
            $display("FAIL reset_mid_uop reg=%0d required=1", bus.UOP_REG);
        end
        next_cycle();
        rst = 1'b0;
        set_in(16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (all_out() !== 28'd0 || bus.DBG_STATE !== IDLE) begin
            errors++;
            $display("FAIL reset_mid_outputs got=%h state=%0d required=0", all_out(), bus.DBG_STATE);
        end
        checks++;
        if (exp_q.size() != 3) begin
            errors++;
            $display("FAIL reset_mid_pending got=%0d required=3", exp_q.size());
        end
        exp_q.delete();
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            set_in(16'h0123, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (all_out() !== 28'd0 || bus.DBG_STATE !== IDLE) begin
                errors++;
                $display("FAIL add_passthrough c=%0d got=%h state=%0d required=0", c, all_out(), bus.DBG_STATE);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            run_seq(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        end
        idle_check("b2b_after");
    endtask

    initial begin
        test_reset();
        test_lm_basic();
        test_sm_full();
        test_zero_mask();
        test_stall();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        next_cycle();
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
Micro-sequencer in the ID stage that expands LM/SM (load/store multiple) instructions into one single-register memory micro-op per set bit of the 8-bit register list.
- Drives the ID_RR input mux while it owns the ID stage.
- Stalls IF/ID until the last micro-op issues.
- Sits beside the pipeline controller, which ORs IF_ID_HOLD into IF_ID_EN gating.

Parameters:
LM_OPCODE, 4'b0110, opcode of LM (IR[15:12])
SM_OPCODE, 4'b0111, opcode of SM
ADDR_STEP, 2, address increment per transferred register (byte-addressed memory)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active high
ID_IR  in  16  instruction currently in ID stage
ID_VALID  in  1  ID_IR holds a valid instruction
STALL_IN  in  1  downstream hazard stall; freezes sequencer
FLUSH  in  1  branch/jump flush of ID and younger stages
SEQ_CLAIM  out  1  ID instruction is owned by sequencer; ID_RR takes micro-op or bubble, never ID_IR
IF_ID_HOLD  out  1  hold IF/ID register and PC
UOP_VALID  out  1  micro-op outputs valid this cycle
UOP_IS_LOAD  out  1  1 = LM micro-op, 0 = SM micro-op
UOP_BASE  out  3  base register RA (IR[11:9])
UOP_REG  out  3  data register of this micro-op
UOP_OFFSET  out  16  address offset from base
UOP_FIRST  out  1  first micro-op of the instruction; RR latches base value here
UOP_LAST  out  1  final micro-op of the instruction

Behaviour:
- Register-list decode: IR[7:0]; bit 7 maps to R0, bit 0 maps to R7. Registers issue in ascending index (R0 first).
- States: IDLE, RUN.
- Accept condition: IDLE & ID_VALID & IR[15:12] in {LM_OPCODE, SM_OPCODE} & !STALL_IN & !FLUSH.
- Accept at cycle T, nonzero mask:
  - SEQ_CLAIM=1 and IF_ID_HOLD=1 in T.
  - Latch remaining mask, RA, type; offset_r=0; next state RUN.
- Accept at T, zero mask:
  - SEQ_CLAIM=1 for T only (instruction retires as bubble); IF_ID_HOLD=0.
  - Stay IDLE; no micro-ops.
- RUN, each cycle:
  - UOP_VALID=1, UOP_REG = lowest-index set register in mask_r, UOP_OFFSET = offset_r.
  - UOP_FIRST=1 on the first RUN cycle; UOP_LAST=1 when mask_r has exactly one bit set.
  - SEQ_CLAIM=1.
  - IF_ID_HOLD = !UOP_LAST.
  - On the edge, if !STALL_IN: clear the issued bit and offset_r += ADDR_STEP (16-bit, wraps modulo 2^16). If UOP_LAST, return to IDLE.
- Latency and throughput:
  - N set bits → micro-ops in cycles T+1..T+N, one per unstalled cycle.
  - IF_ID_HOLD asserted T..T+N-1; SEQ_CLAIM asserted T..T+N.
  - Next instruction enters ID at T+N+1.
- STALL_IN in RUN: all registered state and all outputs frozen. Downstream must not consume while stalled. No register is skipped or duplicated.
- STALL_IN in IDLE: no accept.
- FLUSH (priority over STALL_IN):
  - Same cycle: IF_ID_HOLD=0, UOP_VALID=0.
  - Next edge: IDLE, mask cleared.
  - A new LM/SM can be accepted the cycle after.
- Non-LM/SM instructions: SEQ_CLAIM=0, IF_ID_HOLD=0, state unchanged.
- IR[8] is ignored.
- LM whose list contains RA: the sequencer does nothing special. RR captures the base value on UOP_FIRST.
- RST (sync, also mid-RUN): next edge forces IDLE, mask_r=0, offset_r=0. All outputs 0 from the following cycle until a new accept.

Decomposition:
- Shared package (pipeline defines): LM/SM opcodes, IR field positions (RA 11:9, list 7:0), state encoding IDLE/RUN.
- One sub-module: reg_list_pick. Combinational; 8-bit mask in, 3-bit index of lowest-numbered register (bit7→R0), one-hot clear mask, single-bit flag.

Test Plan:
1. LM, RA=R1, list 8'b1010_0001, accepted at T → UOP_REG 0,2,7 at T+1..T+3, offsets 0,2,4, UOP_FIRST at T+1, UOP_LAST at T+3, IS_LOAD=1, IF_ID_HOLD T..T+2, SEQ_CLAIM T..T+3.
2. SM, list 8'hFF → 8 micro-ops R0..R7, offsets 0..14 step 2, IS_LOAD=0, IF_ID_HOLD for 8 cycles, IDLE after T+8.
3. LM, list 8'h00 → SEQ_CLAIM=1 for one cycle, UOP_VALID never 1, IF_ID_HOLD never 1, next instruction accepted at T+1.
4. LM, list 8'b1110_0000; STALL_IN high 3 cycles while UOP_REG=1 → outputs frozen (REG=1, OFFSET=2) for those cycles, then REG=2 OFFSET=4 LAST; total micro-ops 3.
5. FLUSH during second micro-op of a 4-register SM → same cycle UOP_VALID=0 and IF_ID_HOLD=0. Next cycle IDLE; back-to-back LM accepted immediately with offset restarting at 0.
6. RST asserted at T+2 of a 5-register LM → from T+3 all outputs 0, state IDLE. Also: ADD in ID with ID_VALID=1 → SEQ_CLAIM=0, IF_ID_HOLD=0.
